i2s_master: RTL
===============

# i2s_master

I2S bus master for the transceiver's codec side. It derives BCLK and LRCLK from the system clock and serialises a 24-bit stereo sample pair onto DOUT. It also deserialises the returning DIN stream into a 24-bit stereo pair. This is the bus-owning counterpart for devices that run as I2S slaves on the DDC/DUC audio and IQ path.

## Interface
- CLK_DIV, 4: system clocks per BCLK half-period; legal range 1..255.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_left  in  24  left sample to transmit, two's complement.
- tx_right  in  24  right sample to transmit.
- tx_strobe  in  1  one-cycle write of tx_left/tx_right into the holding registers.
- tx_req  out  1  one-cycle pulse when the holding registers are consumed at frame start.
- rx_left  out  24  last received left sample.
- rx_right  out  24  last received right sample.
- rx_valid  out  1  one-cycle pulse when rx_left/rx_right are updated.
- BCLK  out  1  bit clock.
- LRCLK  out  1  word select; low = left, high = right.
- DOUT  out  1  serial data to the slave.
- DIN  in  1  serial data from the slave.

## Operation
- Format: Philips I2S. 64 BCLK per frame, two 32-bit slots, MSB first. Data is delayed one BCLK after the LRCLK edge. Each 24-bit sample occupies the top 24 bits of its slot; the remaining 8 bits are transmitted as 0 and ignored on receive.
- Divider:
  - div_cnt counts 0..CLK_DIV-1.
  - At the terminal count, div_cnt clears and BCLK toggles.
  - A toggle 1→0 is a fall event; a toggle 0→1 is a rise event.
- bit_cnt (6 bits):
  - Resets to 63.
  - Increments on each fall event and wraps 63→0.
  - Bit positions: 0 = left MSB, 23 = left LSB, 32 = right MSB, 55 = right LSB.
- On each fall event:
  - DOUT <= tx_shift[63 - new bit_cnt].
  - LRCLK <= 1 when the new bit_cnt is in 31..62, else 0. This makes LRCLK lead each slot MSB by one BCLK.
- Frame start is the fall event where bit_cnt goes 63→0:
  - tx_shift <= {hold_left, 8'd0, hold_right, 8'd0}.
  - tx_req pulses in the same clock.
  - The `started` flag sets.
- Holding registers:
  - Capture tx_left/tx_right on tx_strobe.
  - If no strobe arrives before the next frame start, the same pair is retransmitted.
  - If tx_strobe coincides with a frame-start load, the load takes the old holding value and the strobe updates the holding registers for the following frame.
- Receive:
  - On each rise event with `started` set, rx_shift[63 - bit_cnt] <= DIN.
  - Rise events before the first frame start are ignored.
- On the rise event with bit_cnt == 63 and `started` set:
  - rx_left <= {rx_shift[63:41], DIN-independent bits already captured}[63:40] (that is, bits for positions 0..23).
  - rx_right <= positions 32..55.
  - rx_valid pulses for one clock.

## Timing
- Reset values:
  - BCLK = 0, LRCLK = 0, DOUT = 0, tx_req = 0, rx_valid = 0, rx_left = rx_right = 0.
  - Holding registers = 0, div_cnt = 0, bit_cnt = 63, `started` = 0.
- BCLK period = 2*CLK_DIV clocks; frame = 128*CLK_DIV clocks.
- First BCLK edge after reset release is a rise at clock CLK_DIV. The first fall, which is also the first frame start, comes at clock 2*CLK_DIV.
- DOUT and LRCLK change in the same clock as BCLK falls, giving the slave half a BCLK period of setup.
- DIN is sampled in the clock where BCLK rises.
- rx latency: rx_valid arrives 8 BCLK after the right LSB was sampled, at the last rise of the frame.
- With CLK_DIV = 1, BCLK toggles every clock; all rules above still hold.
- Reset asserted mid-frame: all state returns to reset values immediately. A partial frame is never reported on rx_valid.

## Configuration
- I2S_MASTER_LOOPBACK_EN:
  - Defined: the receive shifter samples the internal DOUT instead of the DIN pin, and DIN is ignored. Each frame returns the pair transmitted in that same frame.
  - Undefined: the receive shifter samples the DIN pin, with no added logic.

## Test plan
- Reset release with CLK_DIV=4 -> first BCLK rise at clock 4, first fall at clock 8 with tx_req pulsing. LRCLK high for exactly 32 BCLK per 64-BCLK frame, rising one BCLK before bit 32.
- tx_strobe with left=24'h123456, right=24'hABCDEF -> next frame's DOUT bits 0..23 = 0x123456, bits 24..31 = 0, bits 32..55 = 0xABCDEF, bits 56..63 = 0.
- Bench slave drives left=24'h800001, right=24'h7FFFFE on DIN -> rx_valid pulses once per frame with rx_left=24'h800001, rx_right=24'h7FFFFE.
- No tx_strobe for 3 frames -> the same pair is repeated each frame and tx_req still pulses once per frame. A tx_strobe in the tx_req clock appears one frame later.
- Reset asserted at bit 40 of a frame -> all outputs return to reset values within that clock. No rx_valid from the aborted frame; the first new rx_valid comes one full frame after the next frame start.
- I2S_MASTER_LOOPBACK_EN defined, DIN tied to 0, CLK_DIV=1 -> rx_left/rx_right equal the transmitted pair of the same frame.

Source files
------------

// File: rtl/i2s_master.sv
// I2S (Philips) bus master: derives BCLK/LRCLK, serialises a 24-bit stereo pair onto DOUT
// and deserialises DIN. Optional macro I2S_MASTER_LOOPBACK_EN feeds DOUT back into the receiver.
module i2s_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] tx_left,
  input  logic [23:0] tx_right,
  input  logic        tx_strobe,
  output logic        tx_req,
  output logic [23:0] rx_left,
  output logic [23:0] rx_right,
  output logic        rx_valid,
  output logic        BCLK,
  output logic        LRCLK,
  output logic        DOUT,
  input  logic        DIN
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [5:0]  bit_next;
  logic [63:0] tx_shift;
  logic [63:0] tx_load;
  logic [23:0] hold_left;
  logic [23:0] hold_right;
  logic [23:0] rx_left_sh;
  logic [23:0] rx_right_sh;
  logic        started;
  logic        tick;
  logic        fall_evt;
  logic        rise_evt;
  logic        frame_start;
  logic        rx_bit;

`ifdef I2S_MASTER_LOOPBACK_EN
  logic unused_din;
  assign unused_din = DIN;
  assign rx_bit     = DOUT;
`else
  assign rx_bit     = DIN;
`endif

  always_comb begin
    tick        = (div_cnt == DIV_LAST);
    fall_evt    = tick & BCLK;
    rise_evt    = tick & ~BCLK;
    bit_next    = bit_cnt + 6'd1;
    frame_start = fall_evt & (bit_cnt == 6'd63);
    // DOUT for bit 0 must come from the freshly loaded frame, not the stale shifter.
    tx_load     = frame_start ? {hold_left, 8'd0, hold_right, 8'd0} : tx_shift;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      BCLK    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      BCLK    <= ~BCLK;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= '1;
      tx_shift <= '0;
      DOUT     <= 1'b0;
      LRCLK    <= 1'b0;
      tx_req   <= 1'b0;
      started  <= 1'b0;
    end else begin
      tx_req <= 1'b0;
      if (fall_evt) begin
        bit_cnt  <= bit_next;
        tx_shift <= tx_load;
        DOUT     <= tx_load[6'd63 - bit_next];
        LRCLK    <= (bit_next >= 6'd31) && (bit_next <= 6'd62);
        if (frame_start) begin
          tx_req  <= 1'b1;
          started <= 1'b1;
        end
      end
    end
  end

  // Strobe coinciding with a frame-start load lands here after the load took the old pair.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_left  <= '0;
      hold_right <= '0;
    end else if (tx_strobe) begin
      hold_left  <= tx_left;
      hold_right <= tx_right;
    end
  end

  // Shifting in MSB-first is equivalent to writing each slot position directly;
  // the unused 8 trailing bits of each slot are simply never captured.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_left_sh  <= '0;
      rx_right_sh <= '0;
      rx_left     <= '0;
      rx_right    <= '0;
      rx_valid    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rise_evt && started) begin
        if (bit_cnt <= 6'd23)
          rx_left_sh <= {rx_left_sh[22:0], rx_bit};
        if ((bit_cnt >= 6'd32) && (bit_cnt <= 6'd55))
          rx_right_sh <= {rx_right_sh[22:0], rx_bit};
        if (bit_cnt == 6'd63) begin
          rx_left  <= rx_left_sh;
          rx_right <= rx_right_sh;
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule
